// File: rtl/seg7_pkg.sv
// Shared definitions for the two-digit 7-segment scan driver.
// Provides the scan FSM state type, the active-high segment patterns
// (bit 0 = a ... bit 6 = g), the all-off pattern and a BCD validity helper.
package seg7_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 2;

    // Refresh order: tens dead-time, tens, ones dead-time, ones.
    typedef enum logic [1:0] {
        BLANK_T = 2'd0,
        SHOW_T  = 2'd1,
        BLANK_O = 2'd2,
        SHOW_O  = 2'd3
    } scan_state_t;

    localparam logic [SEG_W-1:0] SEG_DIG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_DIG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_DIG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_DIG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_DIG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_DIG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_DIG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_DIG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_DIG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DIG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_OFF   = 7'h00;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] d);
        return d <= DIGIT_W'(9);
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high patterns.
// Ports:
//   digit  in  4  BCD digit (10..15 decode to a dash)
//   seg_c  out 7  segment pattern, bit 0 = a ... bit 6 = g
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    // Digit lookup; any non-decimal code shows a dash.
    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0:    seg_c = SEG_DIG_0;
            4'd1:    seg_c = SEG_DIG_1;
            4'd2:    seg_c = SEG_DIG_2;
            4'd3:    seg_c = SEG_DIG_3;
            4'd4:    seg_c = SEG_DIG_4;
            4'd5:    seg_c = SEG_DIG_5;
            4'd6:    seg_c = SEG_DIG_6;
            4'd7:    seg_c = SEG_DIG_7;
            4'd8:    seg_c = SEG_DIG_8;
            4'd9:    seg_c = SEG_DIG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed two-digit 7-segment driver fed by bin_to_bcd.
// Each digit owns one CLK_DIV-cycle slot that opens with BLANK_CYCLES of
// dead-time. Loaded digits are held pending and committed together at the
// frame boundary so both digits always change in the same frame.
// Ports:
//   clk         in  1  system clock, rising edge
//   rst         in  1  synchronous active-high reset
//   load        in  1  strobe capturing tens/ones into the pending registers
//   tens, ones  in  4  BCD digits
//   lz_blank    in  1  suppress a committed tens digit of 0
//   seg         out 7  shared segment bus (polarity per ACTIVE_LOW_SEG)
//   an          out 2  anodes, an[1] = tens, an[0] = ones (per ACTIVE_LOW_AN)
//   frame_done  out 1  pulse in the first cycle of each frame
//   err         out 1  sticky flag: a committed digit exceeded 9
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter bit          ACTIVE_LOW_SEG = 1'b1,
    parameter bit          ACTIVE_LOW_AN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    input  logic               lz_blank,
    output logic [SEG_W-1:0]   seg,
    output logic [AN_W-1:0]    an,
    output logic               frame_done,
    output logic               err
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_INV    = {SEG_W{ACTIVE_LOW_SEG}};
    localparam logic [AN_W-1:0]  AN_INV     = {AN_W{ACTIVE_LOW_AN}};

    scan_state_t        state, nxt_state;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [DIGIT_W-1:0] pend_t, pend_o, nxt_pend_t, nxt_pend_o;
    logic [DIGIT_W-1:0] disp_t, disp_o, nxt_disp_t, nxt_disp_o;
    logic               commit;
    logic               nxt_err;
    logic [DIGIT_W-1:0] cur_digit;
    logic [SEG_W-1:0]   cur_pat;
    logic [SEG_W-1:0]   seg_act;
    logic [AN_W-1:0]    an_act;

    // Slot sequencing; the counter restarts only when a show state ends.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CNT_W'(1);
        commit    = 1'b0;
        case (state)
            BLANK_T: if (cnt == BLANK_LAST) nxt_state = SHOW_T;
            SHOW_T: begin
                if (cnt == SLOT_LAST) begin
                    nxt_state = BLANK_O;
                    nxt_cnt   = '0;
                end
            end
            BLANK_O: if (cnt == BLANK_LAST) nxt_state = SHOW_O;
            SHOW_O: begin
                if (cnt == SLOT_LAST) begin
                    nxt_state = BLANK_T;
                    nxt_cnt   = '0;
                    commit    = 1'b1;
                end
            end
            default: begin
                nxt_state = BLANK_T;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Pending capture and frame-boundary commit; a load in the commit cycle
    // flows straight through to the display registers.
    always_comb begin
        nxt_pend_t = load ? tens : pend_t;
        nxt_pend_o = load ? ones : pend_o;
        nxt_disp_t = commit ? nxt_pend_t : disp_t;
        nxt_disp_o = commit ? nxt_pend_o : disp_o;
        nxt_err    = err | (commit & (~is_bcd_digit(nxt_pend_t) |
                                      ~is_bcd_digit(nxt_pend_o)));
    end

    // Single shared decoder, steered to whichever digit the next state shows.
    assign cur_digit = (nxt_state == SHOW_T) ? nxt_disp_t : nxt_disp_o;

    bcd_to_seg7 u_dec (
        .digit (cur_digit),
        .seg_c (cur_pat)
    );

    // Active-high drive for the upcoming cycle, registered below.
    always_comb begin
        seg_act = SEG_OFF;
        an_act  = '0;
        case (nxt_state)
            SHOW_T: begin
                if (!(lz_blank && (nxt_disp_t == '0))) begin
                    an_act  = 2'b10;
                    seg_act = cur_pat;
                end
            end
            SHOW_O: begin
                an_act  = 2'b01;
                seg_act = cur_pat;
            end
            default: begin
                an_act  = '0;
                seg_act = SEG_OFF;
            end
        endcase
    end

    // State, data and output registers; outputs stay aligned with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BLANK_T;
            cnt        <= '0;
            pend_t     <= '0;
            pend_o     <= '0;
            disp_t     <= '0;
            disp_o     <= '0;
            seg        <= SEG_OFF ^ SEG_INV;
            an         <= AN_INV;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            pend_t     <= nxt_pend_t;
            pend_o     <= nxt_pend_o;
            disp_t     <= nxt_disp_t;
            disp_o     <= nxt_disp_o;
            seg        <= seg_act ^ SEG_INV;
            an         <= an_act ^ AN_INV;
            frame_done <= commit;
            err        <= nxt_err;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (CLK_DIV=8, BLANK_CYCLES=2,
// both polarities active-low): a constant vector table for the first frame,
// directed multi-cycle sequences, and a randomized run compared every cycle
// against a frame-position reference model.
module tb_seg7_scan_driver;

    localparam int CD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 2 * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       lz_blank = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    seg7_scan_driver #(
        .CLK_DIV        (CD),
        .BLANK_CYCLES   (BL),
        .ACTIVE_LOW_SEG (1'b1),
        .ACTIVE_LOW_AN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .tens       (tens),
        .ones       (ones),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // Reference model: the frame is a position 0..FRAME-1; the first CD
    // positions belong to tens, the rest to ones, and the first BL positions
    // of each half are dark.
    typedef struct packed {
        logic       valid;
        int         pos;
        int         pt;
        int         po;
        int         dt;
        int         dd;
        logic       err;
        logic       fd;
        logic [6:0] seg;
        logic [1:0] an;
    } mdl_t;

    mdl_t m = '0;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic mdl_t mdl_step(input mdl_t cur, input logic r, input logic ld,
                                      input int t, input int o, input logic lz);
        mdl_t       n;
        logic [6:0] s_on;
        logic [1:0] a_on;
        n = cur;
        if (r) begin
            n       = '0;
            n.valid = 1'b1;
            n.seg   = 7'h7F;
            n.an    = 2'b11;
            return n;
        end
        if (!cur.valid) return n;
        n.fd = (cur.pos == FRAME - 1);
        if (ld) begin
            n.pt = t;
            n.po = o;
        end
        if (n.fd) begin
            n.dt = n.pt;
            n.dd = n.po;
            if (n.dt > 9 || n.dd > 9) n.err = 1'b1;
        end
        n.pos = (cur.pos + 1) % FRAME;
        s_on  = 7'h00;
        a_on  = 2'b00;
        if ((n.pos % CD) >= BL) begin
            if (n.pos < CD) begin
                if (!(lz && n.dt == 0)) begin
                    a_on = 2'b10;
                    s_on = pat(n.dt);
                end
            end else begin
                a_on = 2'b01;
                s_on = pat(n.dd);
            end
        end
        n.seg = ~s_on;
        n.an  = ~a_on;
        return n;
    endfunction

    always @(posedge clk) m <= mdl_step(m, rst, load, int'(tens), int'(ones), lz_blank);

    // Every cycle after the first reset, the DUT must match the model.
    always @(negedge clk) begin
        if (m.valid) begin
            chk("mdl_seg", 32'(seg), 32'(m.seg));
            chk("mdl_an", 32'(an), 32'(m.an));
            chk("mdl_frame_done", 32'(frame_done), 32'(m.fd));
            chk("mdl_err", 32'(err), 32'(m.err));
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic do_load(input int t, input int o);
        load = 1'b1;
        tens = 4'(t);
        ones = 4'(o);
        tick();
        load = 1'b0;
    endtask

    typedef struct packed {
        int         c;
        logic [6:0] seg;
        logic [1:0] an;
        logic       fd;
    } vec_t;

    vec_t vt[10];

    initial begin
        // First frame after reset with nothing loaded: digits 0/0.
        vt[0] = '{c: 0,  seg: 7'h7F, an: 2'b11, fd: 1'b0};
        vt[1] = '{c: 1,  seg: 7'h7F, an: 2'b11, fd: 1'b0};
        vt[2] = '{c: 2,  seg: 7'h40, an: 2'b01, fd: 1'b0};
        vt[3] = '{c: 7,  seg: 7'h40, an: 2'b01, fd: 1'b0};
        vt[4] = '{c: 8,  seg: 7'h7F, an: 2'b11, fd: 1'b0};
        vt[5] = '{c: 9,  seg: 7'h7F, an: 2'b11, fd: 1'b0};
        vt[6] = '{c: 10, seg: 7'h40, an: 2'b10, fd: 1'b0};
        vt[7] = '{c: 15, seg: 7'h40, an: 2'b10, fd: 1'b0};
        vt[8] = '{c: 16, seg: 7'h7F, an: 2'b11, fd: 1'b1};
        vt[9] = '{c: 17, seg: 7'h7F, an: 2'b11, fd: 1'b0};

        do_reset();
        chk("rst_err", 32'(err), 32'd0);
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) tick();
            for (int i = 0; i < 10; i++) begin
                if (vt[i].c == c) begin
                    chk("vec_seg", 32'(seg), 32'(vt[i].seg));
                    chk("vec_an", 32'(an), 32'(vt[i].an));
                    chk("vec_frame_done", 32'(frame_done), 32'(vt[i].fd));
                end
            end
        end

        // Load 3/1 mid-frame: frame 0 keeps 0/0, frame 1 shows 3/1.
        do_reset();
        wait_cyc(4);
        do_load(3, 1);
        wait_cyc(10);
        chk("ld_old_ones_seg", 32'(seg), 32'h40);
        wait_cyc(18);
        chk("ld_tens_seg", 32'(seg), 32'h30);
        chk("ld_tens_an", 32'(an), 32'h1);
        wait_cyc(26);
        chk("ld_ones_seg", 32'(seg), 32'h79);
        chk("ld_ones_an", 32'(an), 32'h2);

        // Leading-zero blanking of a committed tens 0.
        do_reset();
        lz_blank = 1'b1;
        do_load(0, 5);
        wait_cyc(16);
        for (int c = 16; c < 32; c++) begin
            chk("lz_an1_off", 32'(an[1]), 32'd1);
            if (cyc == 26) begin
                chk("lz_ones_seg", 32'(seg), 32'h12);
                chk("lz_ones_an", 32'(an), 32'h2);
            end
            tick();
        end
        lz_blank = 1'b0;

        // Two loads before one commit; the second lands in the commit cycle.
        do_reset();
        wait_cyc(5);
        do_load(1, 8);
        wait_cyc(15);
        do_load(2, 0);
        wait_cyc(18);
        chk("lww_tens_seg", 32'(seg), 32'h24);
        wait_cyc(26);
        chk("lww_ones_seg", 32'(seg), 32'h40);
        wait_cyc(34);
        chk("lww_tens_seg2", 32'(seg), 32'h24);

        // Invalid ones digit: dash and sticky err.
        do_reset();
        wait_cyc(3);
        do_load(1, 12);
        wait_cyc(15);
        chk("err_before_commit", 32'(err), 32'd0);
        tick();
        chk("err_at_commit", 32'(err), 32'd1);
        chk("err_frame_done", 32'(frame_done), 32'd1);
        wait_cyc(18);
        chk("err_tens_seg", 32'(seg), 32'h79);
        wait_cyc(26);
        chk("err_dash_seg", 32'(seg), 32'h3F);
        chk("err_dash_an", 32'(an), 32'h2);
        wait_cyc(43);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset during SHOW_O with a pending load.
        do_load(7, 7);
        rst = 1'b1;
        tick();
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_an", 32'(an), 32'h3);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        cyc = 0;
        wait_cyc(16);
        chk("post_rst_fd", 32'(frame_done), 32'd1);
        wait_cyc(18);
        chk("post_rst_tens", 32'(seg), 32'h40);
        wait_cyc(26);
        chk("post_rst_ones", 32'(seg), 32'h40);
        chk("post_rst_err", 32'(err), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tens = 4'($urandom_range(0, 15));
                ones = 4'($urandom_range(0, 15));
            end else begin
                tens = 4'($urandom_range(0, 9));
                ones = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 39) == 0) lz_blank = ~lz_blank;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst  = 1'b0;
        load = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed two-digit 7-segment driver that sits directly downstream of `bin_to_bcd`, consuming its `tens`/`ones` BCD digits and driving a shared segment bus plus two digit anodes. Each digit is shown in its own refresh slot, separated by a blanking dead-time to prevent ghosting. Inputs are captured by a load strobe and committed only at frame boundaries, so both digits always update together. Optional leading-zero blanking and invalid-BCD flagging are included.

## Interface
- `CLK_DIV`, 50000: clock cycles per digit slot; must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 16: dead-time cycles at the start of each slot with all anodes off; must be ≥ 1.
- `ACTIVE_LOW_SEG`, 1: 1 inverts `seg` (common-anode panel).
- `ACTIVE_LOW_AN`, 1: 1 inverts `an`.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `tens`/`ones` into the pending registers.
- `tens`  in  4  BCD tens digit from `bin_to_bcd`.
- `ones`  in  4  BCD ones digit from `bin_to_bcd`.
- `lz_blank`  in  1  1 = suppress the tens digit when its committed value is 0.
- `seg`  out  7  segments, `seg[0]`=a … `seg[6]`=g.
- `an`  out  2  anodes, `an[1]`=tens, `an[0]`=ones.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.
- `err`  out  1  sticky: a committed digit was > 9.

## Operation
- FSM states: `BLANK_T` → `SHOW_T` → `BLANK_O` → `SHOW_O` → `BLANK_T`.
- Slot counter counts 0..`CLK_DIV`-1 per slot. A blank state lasts `BLANK_CYCLES` cycles; a show state lasts `CLK_DIV`-`BLANK_CYCLES` cycles. Frame length = 2×`CLK_DIV`.
- Blank states: anodes off, segments off.
- `SHOW_T`: `an[1]` on, tens pattern. If `lz_blank`=1 and committed tens = 0, `an[1]` stays off.
- `SHOW_O`: `an[0]` on, ones pattern. The ones digit is never blanked.
- Segment patterns (active-high, hex g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10–15 displays dash = 40.
- `load` writes the pending registers. Pending values are copied to the display registers only on the `SHOW_O`→`BLANK_T` transition (commit).
- If `load` and commit coincide, the `load` inputs are committed directly (bypass).
- A later `load` before commit overwrites the earlier one; last write wins.
- `err` is set on a commit whose tens or ones value is > 9, and clears only on `rst`.
- `frame_done` asserts in the first cycle of `BLANK_T`, i.e. in the same cycle the committed values appear internally.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- On `rst`:
  - state = `BLANK_T`, counter = 0.
  - Pending and display registers = 0.
  - `seg` and `an` = inactive after polarity (all 1s when active-low).
  - `frame_done` = 0, `err` = 0.
  - `load` is ignored while `rst` is high.
- Reset asserted mid-frame takes effect on the next edge: display goes dark and pending data is lost.
- Relative to the first cycle after reset release (frame cycle 0):
  - `an[1]` is active for frame cycles `BLANK_CYCLES`..`CLK_DIV`-1.
  - `an[0]` is active for frame cycles `CLK_DIV`+`BLANK_CYCLES`..2×`CLK_DIV`-1.
  - `frame_done` pulses at cycle 2×`CLK_DIV`, then every 2×`CLK_DIV` cycles.
- Latency from `load` to visible digits: up to one frame plus `BLANK_CYCLES`.
- The counter wraps to 0 on every state change that ends a show state.

## Structure
- Shared package `seg7_pkg`:
  - FSM state enum.
  - The 10 digit patterns plus the dash pattern.
  - `SEG_OFF` constant.
- Sub-module `bcd_to_seg7`: purely combinational 4-bit → 7-bit active-high decoder. It is instantiated once, muxed by the current digit; the polarity inversion happens in the output register.

## Test plan
All scenarios use `CLK_DIV`=8, `BLANK_CYCLES`=2, both polarities active-low.
- Reset release, no load → `seg`=7F and `an`=11 for the first 2 cycles. Then `an`=01 with `seg`=40 (digit 0) for 6 cycles; `an`=11 for 2 cycles; `an`=10 with `seg`=40 for 6 cycles; `frame_done` pulses at cycle 16.
- `load` tens=3, ones=1 at cycle 4 → frame 0 still shows 0/0. From cycle 18, tens shows `seg`=30 (~4F) and later ones shows `seg`=79 (~06).
- `lz_blank`=1, committed tens=0, ones=5 → `an[1]` never goes low. `an[0]` is low with `seg`=12 (~6D).
- Two loads before one commit (1/8, then 2/0), with the second load in the commit cycle → display shows 2/0 and never 1/8.
- `load` tens=1, ones=12 → ones slot shows `seg`=3F (dash, inverted). `err` rises in the commit cycle and remains 1 until `rst`.
- Assert `rst` during `SHOW_O` with a pending load → next cycle all outputs are inactive. The following frame shows 0/0 and `err`=0.
